// File: rtl/tone_pkg.sv
// Shared constants and types for the tone detector and the square-wave note
// generators.
//   NUM_NOTES    : number of recognised notes (C4..C5 white/black subset)
//   note_idx_t   : 3-bit note index
//   state_t      : detector FSM state encoding
//   HALF_US      : half-period of each note in microseconds
//   note_period(): full period in clk cycles for note k at clk_mhz
//   note_tol()   : match tolerance in clk cycles for a given period
package tone_pkg;

  localparam int NUM_NOTES = 8;

  typedef logic [2:0] note_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // C4, D4, E4, F4, G4, A4, B4, C5
  localparam int HALF_US [NUM_NOTES] = '{1911, 1703, 1517, 1432, 1276, 1136, 1012, 956};

  // The generators hold each half for clk_mhz*H+1 cycles, so a full period
  // is twice that.
  function automatic int note_period(input int clk_mhz, input int k);
    return 2 * (clk_mhz * HALF_US[k] + 1);
  endfunction

  function automatic int note_tol(input int p, input int shift);
    return p >> shift;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Reusable for any asynchronous pin input.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_async : asynchronous input level
//   o_rise  : one-cycle pulse, high in the cycle after the synchronized
//             level first reads 1 (two clocks after the input is sampled)
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  // Built only from flops, so the pulse is glitch-free.
  assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/tone_detector.sv
// Measures the period of an incoming 50%-duty tone and identifies which of
// the NUM_NOTES fixed notes it is, locking only after CONFIRM consecutive
// matching periods.
//   clk           : system clock, CLK_MHZ MHz
//   rst_n         : asynchronous active-low reset
//   enable        : low forces IDLE and flushes the measurement pipeline
//   tone_in       : asynchronous square-wave input
//   note_valid    : high while locked on a note
//   note_code     : locked note index; holds its last value when not valid
//   period        : last measured full period in clk cycles
//   note_change   : one-cycle pulse when a lock is acquired
//   o_dbg_state   : current FSM state
//   o_dbg_confirm : current consecutive-match count
// Pipeline: edge pulse E -> period_q (end of E) -> match (next clock) ->
// FSM/outputs (next clock), i.e. outputs move two clocks after E is sampled.
// CNT_W must be wide enough to hold the longest note period at CLK_MHZ.
module tone_detector
  import tone_pkg::*;
#(
  parameter int CLK_MHZ   = 20,
  parameter int CNT_W     = 20,
  parameter int TOL_SHIFT = 6,
  parameter int CONFIRM   = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic                             tone_in,
  output logic                             note_valid,
  output note_idx_t                        note_code,
  output logic [CNT_W-1:0]                 period,
  output logic                             note_change,
  output state_t                           o_dbg_state,
  output logic [$clog2(CONFIRM+1)-1:0]     o_dbg_confirm
);

  localparam int CW = $clog2(CONFIRM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------- input path and period counter ----------------
  logic             w_edge;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_p;
  logic             w_timeout;

  sync_edge_detect u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_async (tone_in),
    .o_rise  (w_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!enable || w_edge) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A saturated counter reports the saturated value, which never matches.
  assign w_p       = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
  // An edge in the saturation cycle takes precedence over the timeout.
  assign w_timeout = (r_cnt == CNT_MAX) && !w_edge;

  // ---------------- FSM state registers (declared early) ----------------
  state_t           r_state;
  logic [CW-1:0]    r_confirm;
  note_idx_t        r_cand;
  logic             r_valid;
  note_idx_t        r_code;
  logic             r_change;
  logic [CNT_W-1:0] r_period_o;

  // ---------------- stage 1: capture period ----------------
  logic [CNT_W-1:0] r_period_q;
  logic             r_pq_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_q <= '0;
      r_pq_vld   <= 1'b0;
    end else begin
      // The first edge after IDLE only provides a reference; drop it.
      r_pq_vld <= enable && w_edge && (r_state != ST_IDLE);
      if (w_edge) begin
        r_period_q <= w_p;
      end
    end
  end

  // ---------------- stage 2: window match ----------------
  logic [NUM_NOTES-1:0] w_win;
  logic                 w_hit;
  note_idx_t            w_idx;

  for (genvar k = 0; k < NUM_NOTES; k++) begin : g_win
    localparam int PK = note_period(CLK_MHZ, k);
    localparam int TK = note_tol(PK, TOL_SHIFT);
    localparam logic [CNT_W-1:0] PK_V = CNT_W'(PK);
    logic [CNT_W-1:0] w_diff;
    assign w_diff   = (r_period_q >= PK_V) ? (r_period_q - PK_V) : (PK_V - r_period_q);
    assign w_win[k] = (w_diff <= CNT_W'(TK));
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    w_idx = '0;
    for (int k = NUM_NOTES - 1; k >= 0; k--) begin
      if (w_win[k]) begin
        w_idx = note_idx_t'(k);
      end
    end
  end

  assign w_hit = |w_win;

  logic             r_m_vld;
  logic             r_m_hit;
  note_idx_t        r_m_idx;
  logic [CNT_W-1:0] r_m_period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_vld    <= 1'b0;
      r_m_hit    <= 1'b0;
      r_m_idx    <= '0;
      r_m_period <= '0;
    end else begin
      r_m_vld    <= enable && r_pq_vld;
      r_m_hit    <= w_hit;
      r_m_idx    <= w_idx;
      r_m_period <= r_period_q;
    end
  end

  // ---------------- stage 3: FSM ----------------
  state_t           w_state_n;
  logic [CW-1:0]    w_confirm_n;
  logic [CW-1:0]    w_conf_inc;
  note_idx_t        w_cand_n;
  logic             w_valid_n;
  note_idx_t        w_code_n;
  logic             w_change_n;
  logic [CNT_W-1:0] w_period_n;

  assign w_conf_inc = r_confirm + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_confirm  <= '0;
      r_cand     <= '0;
      r_valid    <= 1'b0;
      r_code     <= '0;
      r_change   <= 1'b0;
      r_period_o <= '0;
    end else begin
      r_state    <= w_state_n;
      r_confirm  <= w_confirm_n;
      r_cand     <= w_cand_n;
      r_valid    <= w_valid_n;
      r_code     <= w_code_n;
      r_change   <= w_change_n;
      r_period_o <= w_period_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_confirm_n = r_confirm;
    w_cand_n    = r_cand;
    w_valid_n   = r_valid;
    w_code_n    = r_code;
    w_change_n  = 1'b0;
    w_period_n  = r_period_o;

    if (!enable) begin
      w_state_n   = ST_IDLE;
      w_valid_n   = 1'b0;
      w_confirm_n = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            w_state_n   = ST_MEASURE;
            w_confirm_n = '0;
          end
        end

        ST_MEASURE: begin
          if (w_timeout) begin
            w_state_n   = ST_IDLE;
            w_confirm_n = '0;
          end else if (r_m_vld) begin
            w_period_n = r_m_period;
            if (!r_m_hit) begin
              w_confirm_n = '0;
            end else begin
              if (r_m_idx == r_cand) begin
                w_confirm_n = w_conf_inc;
              end else begin
                w_cand_n    = r_m_idx;
                w_confirm_n = CW'(1);
              end
              if (w_confirm_n == CW'(CONFIRM)) begin
                w_state_n  = ST_LOCKED;
                w_valid_n  = 1'b1;
                w_code_n   = w_cand_n;
                w_change_n = 1'b1;
              end
            end
          end
        end

        ST_LOCKED: begin
          if (w_timeout) begin
            w_state_n   = ST_IDLE;
            w_valid_n   = 1'b0;
            w_confirm_n = '0;
          end else if (r_m_vld) begin
            w_period_n = r_m_period;
            if (!(r_m_hit && (r_m_idx == r_code))) begin
              // Lose lock immediately; a hit on another note seeds the
              // next candidate so relocking needs only CONFIRM-1 more.
              w_state_n = ST_MEASURE;
              w_valid_n = 1'b0;
              if (r_m_hit) begin
                w_cand_n    = r_m_idx;
                w_confirm_n = CW'(1);
              end else begin
                w_confirm_n = '0;
              end
            end
          end
        end

        default: begin
          w_state_n = ST_IDLE;
        end
      endcase
    end
  end

  assign note_valid    = r_valid;
  assign note_code     = r_code;
  assign period        = r_period_o;
  assign note_change   = r_change;
  assign o_dbg_state   = r_state;
  assign o_dbg_confirm = r_confirm;

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector. Runs at CLK_MHZ=1 with a 12-bit counter so that
// full note periods are ~2000 cycles and the timeout is 4095 cycles.
// Each expected lock is pushed (cycle, code, period) when the locking rise is
// driven; a negedge monitor pops it when note_change pulses.
module tb_tone_detector;

  localparam int CLK_MHZ   = 1;
  localparam int CNT_W     = 12;
  localparam int TOL_SHIFT = 6;
  localparam int CONFIRM   = 3;
  localparam int CW        = $clog2(CONFIRM + 1);
  localparam int EW        = 32 + 3 + CNT_W;

  // Expected periods from the note table: P = 2*(CLK_MHZ*H + 1)
  localparam int P6   = 2 * (CLK_MHZ * 1012 + 1);  // 2026
  localparam int P7   = 2 * (CLK_MHZ * 956 + 1);   // 1914
  localparam int TOL6 = P6 >> TOL_SHIFT;           // 31

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEAS = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic enable  = 1'b0;
  logic tone_in = 1'b0;

  logic             note_valid;
  logic [2:0]       note_code;
  logic [CNT_W-1:0] period;
  logic             note_change;
  logic [1:0]       dbg_state;
  logic [CW-1:0]    dbg_confirm;

  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tone_detector #(
    .CLK_MHZ   (CLK_MHZ),
    .CNT_W     (CNT_W),
    .TOL_SHIFT (TOL_SHIFT),
    .CONFIRM   (CONFIRM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .tone_in       (tone_in),
    .note_valid    (note_valid),
    .note_code     (note_code),
    .period        (period),
    .note_change   (note_change),
    .o_dbg_state   (dbg_state),
    .o_dbg_confirm (dbg_confirm)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  always @(negedge clk) begin
    if (rst_n && note_change) begin
      if (exp_q.size() == 0) begin
        check_eq("chg_unexpected", 32'(note_change), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("chg_cycle",  cyc,                mon_e[EW-1 -: 32]);
        check_eq("chg_code",   32'(note_code),     32'(mon_e[CNT_W +: 3]));
        check_eq("chg_period", 32'(period),        32'(mon_e[CNT_W-1:0]));
        check_eq("chg_valid",  32'(note_valid),    32'd1);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n rising edges spaced per cycles, 50% duty. lock_at names the rise
  // (1-based) that completes the CONFIRM-th matching period, 0 for none.
  // A rise driven just after posedge c is sampled at c+1, gives E at c+3
  // and moves the outputs at c+5.
  task automatic tone_rises(input int per, input int n, input int lock_at, input int code);
    for (int j = 1; j <= n; j++) begin
      tone_in = 1'b1;
      if (j == lock_at) begin
        exp_q.push_back({cyc + 32'd5, 3'(code), CNT_W'(per)});
      end
      repeat (per / 2) @(posedge clk);
      #1;
      tone_in = 1'b0;
      repeat (per - per / 2) @(posedge clk);
      #1;
    end
  endtask

  task automatic disable_pulse();
    enable = 1'b0;
    wait_cyc(3);
    enable = 1'b1;
    wait_cyc(2);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    wait_cyc(3);
    check_eq("rst_valid",   32'(note_valid),  32'd0);
    check_eq("rst_code",    32'(note_code),   32'd0);
    check_eq("rst_period",  32'(period),      32'd0);
    check_eq("rst_change",  32'(note_change), 32'd0);
    check_eq("rst_state",   32'(dbg_state),   32'(S_IDLE));
    check_eq("rst_confirm", 32'(dbg_confirm), 32'd0);

    rst_n  = 1'b1;
    enable = 1'b1;
    wait_cyc(4);

    // Lock on note 6: first rise is reference, rises 2..4 confirm.
    tone_rises(P6, 5, 4, 6);
    check_eq("lock_valid",  32'(note_valid), 32'd1);
    check_eq("lock_code",   32'(note_code),  32'd6);
    check_eq("lock_period", 32'(period),     32'(P6));
    check_eq("lock_state",  32'(dbg_state),  32'(S_LOCK));

    // Switch to note 7: the first P7 measurement drops the lock.
    tone_rises(P7, 2, 0, 0);
    check_eq("chg_fall_valid",  32'(note_valid),  32'd0);
    check_eq("chg_fall_state",  32'(dbg_state),   32'(S_MEAS));
    check_eq("chg_fall_conf",   32'(dbg_confirm), 32'd1);
    check_eq("chg_fall_period", 32'(period),      32'(P7));
    check_eq("chg_fall_code",   32'(note_code),   32'd6);

    // Two more P7 periods relock on 7.
    tone_rises(P7, 2, 2, 7);
    check_eq("relock_valid", 32'(note_valid), 32'd1);
    check_eq("relock_code",  32'(note_code),  32'd7);

    // Timeout: line held low; counter saturates 4095 cycles after last E.
    wait_cyc(1500);
    check_eq("to_pre_valid", 32'(note_valid), 32'd1);
    wait_cyc(1000);
    check_eq("to_valid",   32'(note_valid),  32'd0);
    check_eq("to_state",   32'(dbg_state),   32'(S_IDLE));
    check_eq("to_period",  32'(period),      32'(P7));
    check_eq("to_code",    32'(note_code),   32'd7);
    check_eq("to_confirm", 32'(dbg_confirm), 32'd0);

    // enable=0 mid-MEASURE.
    tone_rises(P6, 3, 0, 0);
    check_eq("en_confirm", 32'(dbg_confirm), 32'd2);
    check_eq("en_state",   32'(dbg_state),   32'(S_MEAS));
    enable = 1'b0;
    wait_cyc(1);
    check_eq("en_off_state",   32'(dbg_state),   32'(S_IDLE));
    check_eq("en_off_confirm", 32'(dbg_confirm), 32'd0);
    check_eq("en_off_valid",   32'(note_valid),  32'd0);
    wait_cyc(3);
    enable = 1'b1;
    wait_cyc(2);
    tone_rises(P6, 4, 4, 6);
    check_eq("en_relock_valid", 32'(note_valid), 32'd1);

    // Asynchronous reset while locked, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid",  32'(note_valid),  32'd0);
    check_eq("arst_code",   32'(note_code),   32'd0);
    check_eq("arst_period", 32'(period),      32'd0);
    check_eq("arst_change", 32'(note_change), 32'd0);
    check_eq("arst_state",  32'(dbg_state),   32'(S_IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cyc(2);

    // Upper tolerance edge: P6+TOL6 still locks, P6+TOL6+1 never does.
    tone_rises(P6 + TOL6, 4, 4, 6);
    check_eq("tolhi_valid",  32'(note_valid), 32'd1);
    check_eq("tolhi_period", 32'(period),     32'(P6 + TOL6));
    disable_pulse();
    tone_rises(P6 + TOL6 + 1, 4, 0, 0);
    check_eq("tolmiss_valid",   32'(note_valid),  32'd0);
    check_eq("tolmiss_confirm", 32'(dbg_confirm), 32'd0);
    check_eq("tolmiss_state",   32'(dbg_state),   32'(S_MEAS));
    check_eq("tolmiss_period",  32'(period),      32'(P6 + TOL6 + 1));

    // Junk period matching no note.
    disable_pulse();
    tone_rises(1000, 5, 0, 0);
    check_eq("junk_valid",   32'(note_valid),  32'd0);
    check_eq("junk_period",  32'(period),      32'd1000);
    check_eq("junk_confirm", 32'(dbg_confirm), 32'd0);

    wait_cyc(10);
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_detector.md
Name: tone_detector

Overview:
- Receive-side counterpart of the square-wave note generators: measures the period of an incoming 50%-duty tone and identifies which of 8 fixed notes it is.
- Sits between a tone input pin (or a generator's speaker output in loopback) and display/game logic.
- Reports a stable note code only after the tone has been confirmed over several consecutive periods.

Parameters:
- CLK_MHZ, 20, system clock in MHz; same meaning as in the generators.
- CNT_W, 20, period counter width in bits; the counter saturates at 2^CNT_W-1.
- TOL_SHIFT, 6, match tolerance per note k is P_k >> TOL_SHIFT cycles.
- CONFIRM, 3, consecutive matching periods of the same note required to lock.

Ports:
- clk, input, 1, system clock; all logic on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, detector enable; low forces IDLE.
- tone_in, input, 1, asynchronous square-wave input; goes through the synchronizer.
- note_valid, output, 1, high while locked on a note.
- note_code, output, 3, index 0..7 of the locked note; holds its last value when not valid.
- period, output, CNT_W, last measured full period in clk cycles.
- note_change, output, 1, one-cycle pulse when note_valid rises or note_code changes while valid.

Behaviour:
- Reset (rst_n=0, async):
  - State IDLE; all outputs 0; synchronizer, counter and confirm count cleared.
- Input path:
  - tone_in passes through a 2-FF synchronizer, then a registered rising-edge detector; edge pulse E is high for 1 cycle.
- Period counter cnt:
  - Cleared to 0 in the E cycle, otherwise increments, saturating at all-ones.
  - P = cnt+1 at E, i.e. clk cycles between consecutive edge pulses.
- Expected periods, from the package table of half-periods H_k in µs:
  - P_k = 2*(CLK_MHZ*H_k + 1).
  - Match k when |P - P_k| <= (P_k >> TOL_SHIFT).
  - If windows overlap, the lowest index wins. No match = miss.
- Pipeline:
  - At E: P is registered into period_q.
  - E+1: match index and hit flag are registered.
  - E+2: FSM and outputs update.
  - Latency from edge pulse to output = 2 clk.
- States:
  - IDLE: no reference edge yet. First E -> MEASURE with confirm=0; that first edge's P is discarded.
  - MEASURE, on each compare result:
    - Hit with same index as candidate: confirm+1.
    - Hit with a different index: candidate=new index, confirm=1.
    - Miss: confirm=0.
    - When confirm reaches CONFIRM -> LOCKED: note_valid=1, note_code=candidate, note_change pulse.
  - LOCKED, on each compare result:
    - Hit same index: stay.
    - Any other result: note_valid=0 in the same update, go to MEASURE. confirm=1 with candidate=new index if hit, else confirm=0.
- period output:
  - Updates with every compare result in MEASURE/LOCKED.
  - Holds during IDLE, never cleared except by reset.
- Timeout:
  - cnt reaching all-ones while in MEASURE or LOCKED -> IDLE, note_valid=0, confirm=0.
  - No note_change pulse.
- enable=0:
  - Synchronously forces IDLE, note_valid=0, confirm=0, cnt=0.
  - Pipeline results in flight are discarded.
  - Re-enable starts from IDLE; the first edge is again discarded.
- Simultaneous timeout and edge: the edge wins; P = saturated value, which is a miss.
- note_change is never asserted in the same cycle as a note_valid fall.

Decomposition:
- Package tone_pkg holds:
  - NUM_NOTES=8 and the note index typedef (3 bits).
  - Half-period table H_k (µs): 1911, 1703, 1517, 1432, 1276, 1136, 1012, 956 (C4..C5). Shared with the generators.
  - The P_k/tolerance computation as a constant function.
- One sub-module: sync_edge_detect (2-FF sync + rising-edge pulse), reusable for other pin inputs.

Test Plan:
- Lock: tone_in period 40482 clk (k=6) -> after 4th rising edge +4 clk (sync/edge +2, pipe +2), note_valid=1, note_code=6, note_change single pulse, period=40482.
- Tolerance: period 40482+632 -> locks on 6; period 40482+633 -> never valid, confirm stays 0.
- Note change: locked on 6, switch to period 38242 (k=7) -> note_valid falls at first new compare, relocks after 2 more periods with note_code=7, one note_change pulse.
- Timeout: locked, then tone_in held low -> note_valid=0 when cnt saturates (~2^20 clk after last edge), state IDLE, period retains 40482.
- Enable/reset: assert enable=0 mid-MEASURE -> next cycle note_valid=0; on re-enable, lock needs CONFIRM+1 edges. Assert rst_n=0 asynchronously mid-LOCKED -> all outputs 0 immediately.
- Junk input: period 1000 clk -> no lock, note_change never pulses, period=1000 each edge.
